trailer_field_sequencer: RTL and testbench
==========================================

TRAILER_FIELD_SEQUENCER -- requirements
Module: trailer_field_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; port list (clock and reset first):
REQ-002 SP  input  1  clock; one rising edge per CAN bit sample point.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 RX  input  1  bus level at the sample point (0 = dominant, 1 = recessive).
REQ-005 CRC_Start  input  1  high at the SP edge of the last data-field bit; the next SP edge samples CRC bit 14.
REQ-006 Stuff_Skip  input  1  high when the current sample is a stuff bit; honoured only in CRC state.
REQ-007 CRC_Calc  input  15  CRC computed upstream; stable from CRC_Start until ACK_SLOT.
REQ-008 EOF_Flag  output  1  active-low, one-bit pulse: low at the SP edge of EOF bit 1, consumed by the EOF error checker.
REQ-009 CRC_Error, CRC_Delim_Error, ACK_Error, ACK_Delim_Error  output  1 each  active-low error flags (1 = no error).
REQ-010 Busy  output  1  high while any trailer field is being sequenced.

Function
REQ-011 SHALL implement the states IDLE, CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM and EOF, advancing only on SP rising edges.
REQ-012 IDLE: when CRC_Start = 1, SHALL go to CRC, clear the bit counter, set all four error flags to 1, and set Busy = 1.
REQ-013 CRC: on each SP with Stuff_Skip = 0, SHALL shift RX into a 15-bit capture register (MSB first) and increment the counter.
REQ-014 CRC: Stuff_Skip = 1 SHALL hold both the counter and the capture register.
REQ-015 CRC: after the 15th captured bit, SHALL go to CRC_DELIM.
REQ-016 CRC_DELIM: RX = 0 SHALL set CRC_Delim_Error = 0 and go to IDLE with Busy = 0 (form error, no EOF_Flag pulse); RX = 1 SHALL go to ACK_SLOT.
REQ-017 ACK_SLOT: SHALL compare the capture register with CRC_Calc and set CRC_Error = 0 on mismatch.
REQ-018 ACK_SLOT: RX = 1 SHALL set ACK_Error = 0; the block SHALL go to ACK_DELIM regardless of RX.
REQ-019 ACK_DELIM: RX = 0 SHALL set ACK_Delim_Error = 0 and go to IDLE with no pulse.
REQ-020 ACK_DELIM: RX = 1 SHALL register EOF_Flag <= 0, clear the counter and go to EOF.
REQ-021 EOF_Flag SHALL return to 1 on the next SP edge; its low width SHALL be exactly one SP period.
REQ-022 EOF: SHALL count 7 SP edges and then go to IDLE with Busy = 0; RX is not checked here (the downstream EOF checker owns it).
REQ-023 Error flags SHALL be sticky until the next CRC_Start or reset.
REQ-024 CRC_Start asserted outside IDLE SHALL abort the current frame and restart at CRC, with the same effects as REQ-012.
REQ-025 The bit counter SHALL be 4 bits wide and SHALL never wrap; its terminal values are 15 (CRC) and 7 (EOF).

Reset
REQ-026 While reset = 1, irrespective of SP: state = IDLE, counter = 0, capture register = 0, EOF_Flag = 1, all error flags = 1, Busy = 0.
REQ-027 Reset asserted mid-frame SHALL suppress any pending EOF_Flag pulse.

Configuration
REQ-028 Macro TRAILER_ACK_CHECK_EN defined: ACK_SLOT SHALL evaluate RX as in REQ-018.
REQ-029 Macro TRAILER_ACK_CHECK_EN undefined: ACK_Error SHALL be constant 1; ACK_SLOT SHALL only advance the state; all other behaviour is unchanged.

Structure
REQ-030 Package can_pkg SHALL hold the state encoding and the constants CRC_LEN = 15 and EOF_LEN = 7.
REQ-031 The 15-bit capture register with stuff-hold SHALL be a sub-module, crc_field_capture (inputs SP, reset, shift_en, RX; output crc_rx[14:0]).

Verification
REQ-032 Clean frame: CRC_Calc = 15'h4A3F, matching CRC bits, delimiters 1, ACK 0 -> EOF_Flag low for one SP, exactly 19 SP edges after CRC_Start; all errors 1; Busy drops after EOF bit 7.
REQ-033 Stuff bits: two Stuff_Skip pulses inside the CRC field -> capture still equals 15'h4A3F; EOF_Flag low 21 SP edges after CRC_Start.
REQ-034 CRC mismatch: received CRC 15'h4A3E vs CRC_Calc 15'h4A3F -> CRC_Error = 0 from the ACK_SLOT edge; EOF_Flag pulse still occurs.
REQ-035 Form errors: CRC delimiter RX = 0 -> CRC_Delim_Error = 0, no pulse, IDLE. Separately, ACK delimiter RX = 0 -> ACK_Delim_Error = 0, no pulse.
REQ-036 ACK missing: RX = 1 in the slot -> ACK_Error = 0 with the macro defined, 1 without it.
REQ-037 Reset asserted in ACK_DELIM -> outputs immediately at reset values; no EOF_Flag pulse on following SP edges.

Source files
------------

// File: rtl/can_pkg.sv
// Shared state encoding, field lengths and error-flag bundle for the CAN trailer sequencer.
package can_pkg;

  localparam int unsigned CRC_LEN = 15;
  localparam int unsigned EOF_LEN = 7;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_CRC_DELIM,
    ST_ACK_SLOT,
    ST_ACK_DELIM,
    ST_EOF
  } state_e;

  // Active-low error flags, 1 = no error
  typedef struct packed {
    logic crc;
    logic crc_delim;
    logic ack;
    logic ack_delim;
  } err_flags_t;

endpackage

// File: rtl/trailer_field_sequencer_if.sv
// Bit-level bus between the CAN receive front end and the trailer field sequencer.
interface trailer_field_sequencer_if;
  import can_pkg::*;

  logic               RX;
  logic               CRC_Start;
  logic               Stuff_Skip;
  logic [CRC_LEN-1:0] CRC_Calc;
  logic               EOF_Flag;
  logic               CRC_Error;
  logic               CRC_Delim_Error;
  logic               ACK_Error;
  logic               ACK_Delim_Error;
  logic               Busy;

  modport master (
    output RX, CRC_Start, Stuff_Skip, CRC_Calc,
    input  EOF_Flag, CRC_Error, CRC_Delim_Error, ACK_Error, ACK_Delim_Error, Busy
  );

  modport slave (
    input  RX, CRC_Start, Stuff_Skip, CRC_Calc,
    output EOF_Flag, CRC_Error, CRC_Delim_Error, ACK_Error, ACK_Delim_Error, Busy
  );

endinterface

// File: rtl/crc_field_capture.sv
// 15-bit MSB-first shift register capturing the received CRC; holds while shift_en is low.
module crc_field_capture
  import can_pkg::*;
(
  input  logic               SP,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               RX,
  output logic [CRC_LEN-1:0] crc_rx
);

  logic [CRC_LEN-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (shift_en) crc_d = {crc_q[CRC_LEN-2:0], RX};
  end

  always_ff @(posedge SP or posedge reset) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_rx = crc_q;

endmodule

// File: rtl/trailer_field_sequencer.sv
// Sequences CRC, CRC delimiter, ACK slot/delimiter and EOF of a CAN frame.
// Define TRAILER_ACK_CHECK_EN to flag a recessive ACK slot on ACK_Error.
module trailer_field_sequencer
  import can_pkg::*;
(
  input  logic                      SP,
  input  logic                      reset,
  trailer_field_sequencer_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  err_flags_t         err_q, err_d;
  logic               eof_flag_q, eof_flag_d;
  logic               busy_q, busy_d;
  logic               shift_en_c;
  logic [CRC_LEN-1:0] crc_rx;

  crc_field_capture u_capture (
    .SP       (SP),
    .reset    (reset),
    .shift_en (shift_en_c),
    .RX       (bus.RX),
    .crc_rx   (crc_rx)
  );

  // Next-state and output logic; CRC_Start restarts the trailer from any state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    eof_flag_d = 1'b1;
    busy_d     = busy_q;
    shift_en_c = 1'b0;

    if (bus.CRC_Start) begin
      state_d = ST_CRC;
      cnt_d   = '0;
      err_d   = '1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_CRC: begin
          if (!bus.Stuff_Skip) begin
            shift_en_c = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CRC_LEN - 1)) state_d = ST_CRC_DELIM;
          end
        end
        ST_CRC_DELIM: begin
          if (!bus.RX) begin
            err_d.crc_delim = 1'b0;
            state_d         = ST_IDLE;
            busy_d          = 1'b0;
          end else begin
            state_d = ST_ACK_SLOT;
          end
        end
        ST_ACK_SLOT: begin
          if (crc_rx != bus.CRC_Calc) err_d.crc = 1'b0;
`ifdef TRAILER_ACK_CHECK_EN
          if (bus.RX) err_d.ack = 1'b0;
`endif
          state_d = ST_ACK_DELIM;
        end
        ST_ACK_DELIM: begin
          if (!bus.RX) begin
            err_d.ack_delim = 1'b0;
            state_d         = ST_IDLE;
            busy_d          = 1'b0;
          end else begin
            eof_flag_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_EOF;
          end
        end
        ST_EOF: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(EOF_LEN - 1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= '1;
      eof_flag_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      eof_flag_q <= eof_flag_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.EOF_Flag        = eof_flag_q;
  assign bus.CRC_Error       = err_q.crc;
  assign bus.CRC_Delim_Error = err_q.crc_delim;
  assign bus.ACK_Error       = err_q.ack;
  assign bus.ACK_Delim_Error = err_q.ack_delim;
  assign bus.Busy            = busy_q;

endmodule

// File: tb/tb_trailer_field_sequencer.sv
// Self-checking bench for trailer_field_sequencer: frame table, corner sequences, random frames.
module tb_trailer_field_sequencer;
  import can_pkg::*;

`ifdef TRAILER_ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic SP    = 1'b0;
  logic reset = 1'b1;

  trailer_field_sequencer_if bus();

  trailer_field_sequencer dut (
    .SP    (SP),
    .reset (reset),
    .bus   (bus)
  );

  always #5 SP = ~SP;

  int n_checks = 0;
  int n_fail   = 0;

  // A frame trailer as seen on the bus, plus what should come out of it.
  // Edge k = k-th SP edge after the CRC_Start edge; exp_pulse is the edge at
  // which the EOF consumer sees EOF_Flag low; flags = {CRC,CRC_Delim,ACK,ACK_Delim}.
  typedef struct {
    logic [14:0] rx_crc;
    logic [14:0] calc;
    int          stuff_a;
    int          stuff_b;
    logic        crc_delim;
    logic        ack;
    logic        ack_delim;
    int          exp_pulse;
    int          exp_busy;
    int          exp_fall;
    logic [3:0]  exp_flags;
  } vec_t;

  typedef struct {
    int         pulse_at;
    int         pulse_cnt;
    int         busy_drop;
    int         crc_fall;
    logic [3:0] flags;
  } obs_t;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.CRC_Error, bus.CRC_Delim_Error, bus.ACK_Error, bus.ACK_Delim_Error};
  endfunction

  function automatic vec_t mk(input logic [14:0] rx_crc, input logic [14:0] calc,
                              input int sa, input int sb, input logic cd, input logic ack,
                              input logic ad, input int pulse, input int busy, input int fall,
                              input logic [3:0] flags);
    vec_t v;
    v.rx_crc = rx_crc; v.calc = calc; v.stuff_a = sa; v.stuff_b = sb;
    v.crc_delim = cd; v.ack = ack; v.ack_delim = ad;
    v.exp_pulse = pulse; v.exp_busy = busy; v.exp_fall = fall; v.exp_flags = flags;
    return v;
  endfunction

  // Reference: field boundaries in SP edges, derived from the frame layout
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int crc_end = 15 + int'(v.stuff_a >= 0) + int'(v.stuff_b >= 0);
    r.exp_fall  = -1;
    r.exp_flags = 4'hF;
    if (!v.crc_delim) begin
      r.exp_pulse    = -1;
      r.exp_busy     = crc_end + 1;
      r.exp_flags[2] = 1'b0;
      return r;
    end
    if (v.rx_crc != v.calc) begin
      r.exp_flags[3] = 1'b0;
      r.exp_fall     = crc_end + 2;
    end
    if (ACK_EN && v.ack) r.exp_flags[1] = 1'b0;
    if (!v.ack_delim) begin
      r.exp_pulse    = -1;
      r.exp_busy     = crc_end + 3;
      r.exp_flags[0] = 1'b0;
    end else begin
      r.exp_pulse = crc_end + 4;
      r.exp_busy  = crc_end + 3 + int'(EOF_LEN);
    end
    return r;
  endfunction

  // Start a frame and drive up to max_edges bits after the CRC_Start edge
  task automatic run_frame(input vec_t v, input int max_edges, output obs_t o);
    logic rx_q[$];
    logic sk_q[$];
    o.pulse_at = -1; o.pulse_cnt = 0; o.busy_drop = -1; o.crc_fall = -1; o.flags = 4'hF;
    for (int i = 0; i < 15; i++) begin
      if (v.stuff_a == i) begin rx_q.push_back(1'($urandom)); sk_q.push_back(1'b1); end
      if (v.stuff_b == i) begin rx_q.push_back(1'($urandom)); sk_q.push_back(1'b1); end
      rx_q.push_back(v.rx_crc[14-i]); sk_q.push_back(1'b0);
    end
    rx_q.push_back(v.crc_delim); sk_q.push_back(1'b0);
    rx_q.push_back(v.ack);       sk_q.push_back(1'b0);
    rx_q.push_back(v.ack_delim); sk_q.push_back(1'b0);
    for (int i = 0; i < 10; i++) begin rx_q.push_back(1'b1); sk_q.push_back(1'b0); end

    bus.CRC_Calc   = v.calc;
    bus.Stuff_Skip = 1'b0;
    bus.RX         = 1'($urandom);
    bus.CRC_Start  = 1'b1;
    @(posedge SP); #1;
    bus.CRC_Start  = 1'b0;
    check_int("busy_after_start", int'(bus.Busy), 1);
    check_int("flags_after_start", int'(flags_now()), 15);

    for (int k = 1; k <= rx_q.size() && k <= max_edges; k++) begin
      bus.RX         = rx_q[k-1];
      bus.Stuff_Skip = sk_q[k-1];
      @(posedge SP); #1;
      if (!bus.EOF_Flag) begin
        o.pulse_cnt++;
        if (o.pulse_at < 0) o.pulse_at = k + 1;
      end
      if (!bus.Busy && o.busy_drop < 0) o.busy_drop = k;
      if (!bus.CRC_Error && o.crc_fall < 0) o.crc_fall = k;
    end
    bus.Stuff_Skip = 1'b0;
    o.flags = flags_now();
  endtask

  task automatic check_frame(input string tag, input vec_t v, input obs_t o);
    check_int({tag, "_eof_pulse_edge"}, o.pulse_at, v.exp_pulse);
    check_int({tag, "_eof_pulse_width"}, o.pulse_cnt, (v.exp_pulse < 0) ? 0 : 1);
    check_int({tag, "_busy_drop_edge"}, o.busy_drop, v.exp_busy);
    check_int({tag, "_crc_err_edge"}, o.crc_fall, v.exp_fall);
    check_int({tag, "_flags"}, int'(o.flags), int'(v.exp_flags));
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    obs_t o;
    int   sel;

    bus.RX = 1'b1; bus.CRC_Start = 1'b0; bus.Stuff_Skip = 1'b0; bus.CRC_Calc = '0;

    repeat (2) @(posedge SP);
    #1;
    check_int("reset_eof_flag", int'(bus.EOF_Flag), 1);
    check_int("reset_busy", int'(bus.Busy), 0);
    check_int("reset_flags", int'(flags_now()), 15);
    reset = 1'b0;
    @(posedge SP); #1;

    tbl[0] = mk(15'h4A3F, 15'h4A3F, -1, -1, 1, 0, 1, 19, 25, -1, 4'b1111);
    tbl[1] = mk(15'h4A3F, 15'h4A3F,  3,  9, 1, 0, 1, 21, 27, -1, 4'b1111);
    tbl[2] = mk(15'h4A3E, 15'h4A3F, -1, -1, 1, 0, 1, 19, 25, 17, 4'b0111);
    tbl[3] = mk(15'h4A3F, 15'h4A3F, -1, -1, 0, 0, 1, -1, 16, -1, 4'b1011);
    tbl[4] = mk(15'h4A3F, 15'h4A3F, -1, -1, 1, 0, 0, -1, 18, -1, 4'b1110);
    tbl[5] = mk(15'h4A3F, 15'h4A3F, -1, -1, 1, 1, 1, 19, 25, -1, {2'b11, ~ACK_EN, 1'b1});
    tbl[6] = mk(15'h0001, 15'h4A3F,  0, -1, 1, 0, 0, -1, 19, 18, 4'b0110);
    tbl[7] = mk(15'h7FFF, 15'h4A3F, 14, 14, 0, 0, 1, -1, 18, -1, 4'b1011);

    foreach (tbl[i]) begin
      run_frame(tbl[i], 1000, o);
      check_frame($sformatf("table%0d", i), tbl[i], o);
    end

    // Restart inside the CRC field, then inside EOF
    run_frame(tbl[0], 6, o);
    run_frame(tbl[0], 1000, o);
    check_frame("abort_in_crc", tbl[0], o);
    run_frame(tbl[1], 22, o);
    run_frame(tbl[2], 1000, o);
    check_frame("abort_in_eof", tbl[2], o);

    // Reset while in ACK_DELIM with a good delimiter already on the bus
    run_frame(tbl[2], 17, o);
    check_int("pre_reset_crc_err", int'(bus.CRC_Error), 0);
    bus.RX = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_int("async_reset_eof_flag", int'(bus.EOF_Flag), 1);
    check_int("async_reset_busy", int'(bus.Busy), 0);
    check_int("async_reset_flags", int'(flags_now()), 15);
    @(posedge SP); #1;
    check_int("held_reset_eof_flag", int'(bus.EOF_Flag), 1);
    #2 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge SP); #1;
      check_int("post_reset_eof_flag", int'(bus.EOF_Flag), 1);
      check_int("post_reset_busy", int'(bus.Busy), 0);
    end

    // Random frames against the reference model
    for (int n = 0; n < 40; n++) begin
      v.calc = 15'($urandom);
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      v.rx_crc = v.calc;
      else if (sel == 1) v.rx_crc = v.calc ^ (15'(1) << $urandom_range(0, 14));
      else               v.rx_crc = 15'($urandom);
      v.stuff_a   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
      v.stuff_b   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
      v.crc_delim = ($urandom_range(0, 7) != 0);
      v.ack       = 1'($urandom);
      v.ack_delim = ($urandom_range(0, 7) != 0);
      v = model(v);
      run_frame(v, 1000, o);
      check_frame($sformatf("rand%0d", n), v, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
